// File: rtl/cmul_arb_pkg.sv
// Shared definitions for the complex-multiplier round-robin arbiter.
// Holds the default datapath width and pipeline depths, and the tag
// carried alongside each operation through the multiplier latency.
package cmul_arb_pkg;

  localparam int W_DEF        = 20;  // s2.17 fixed point
  localparam int MUL_LAT_DEF  = 3;   // operands -> result
  localparam int CONJ_DLY_DEF = 2;   // operands -> conj sampled by multiplier
  localparam int ID_MAX_W     = 3;   // enough for up to 8 requesters

  // One tag stage: id is sized for the largest supported requester count,
  // the arbiter uses the low ID_W bits.
  typedef struct packed {
    logic                vld;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cmul_rr_pick.sv
// Rotate-priority picker: selects the first asserted request at or after
// ptr_i, wrapping modulo N_REQ.
// Ports:
//   req_i  - request vector (already masked by hold/reset)
//   ptr_i  - starting index of the search
//   gnt_o  - one-hot grant
//   idx_o  - encoded granted index (0 when nothing granted)
//   any_o  - a grant was issued
module cmul_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  int j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/cmul_rr_arbiter.sv
// Round-robin arbiter/sequencer in front of one shared pipelined complex
// multiplier. At most one requester is granted per cycle; its operands are
// forwarded to the multiplier and its id rides a tag pipeline matched to
// the multiplier latency so each result comes back tagged with its owner.
//
// Optional feature macro: CMUL_ARB_CONJ_EN
//   defined   - i_req_conj honoured, conj delay pipeline built
//   undefined - i_req_conj ignored, o_mul_conj tied 0
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid/o_req_ready   per-requester handshake (ready is one-hot grant)
//   i_req_R0/I0/R1/I1         packed operands, requester n at [n*W +: W]
//   i_req_conj                per-requester conjugate select
//   i_hold                    suppresses any grant this cycle
//   o_mul_R0/I0/R1/I1         multiplier operands (0 when idle)
//   o_mul_conj                conjugate select, CONJ_DLY after operands
//   i_mul_R/I                 multiplier results
//   o_res_valid/id/R/I        tagged result, MUL_LAT after grant
//   o_busy                    grant this cycle or any op in flight
module cmul_rr_arbiter
  import cmul_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int W        = W_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int CONJ_DLY = CONJ_DLY_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N_REQ-1:0]     i_req_valid,
  input  logic [N_REQ*W-1:0]   i_req_R0,
  input  logic [N_REQ*W-1:0]   i_req_I0,
  input  logic [N_REQ*W-1:0]   i_req_R1,
  input  logic [N_REQ*W-1:0]   i_req_I1,
  input  logic [N_REQ-1:0]     i_req_conj,
  output logic [N_REQ-1:0]     o_req_ready,
  input  logic                 i_hold,
  output logic [W-1:0]         o_mul_R0,
  output logic [W-1:0]         o_mul_I0,
  output logic [W-1:0]         o_mul_R1,
  output logic [W-1:0]         o_mul_I1,
  output logic                 o_mul_conj,
  input  logic [W-1:0]         i_mul_R,
  input  logic [W-1:0]         i_mul_I,
  output logic                 o_res_valid,
  output logic [ID_W-1:0]      o_res_id,
  output logic [W-1:0]         o_res_R,
  output logic [W-1:0]         o_res_I,
  output logic                 o_busy
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] req_m, gnt;
  logic [ID_W-1:0]  gidx;
  logic             gany;
  tag_t             tag_q [MUL_LAT];
  tag_t             tag_d;

  // Grants are suppressed while in reset so nothing transfers on a cycle
  // whose tag would be wiped anyway.
  assign req_m = (i_rst_n && !i_hold) ? i_req_valid : '0;

  cmul_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .req_i (req_m),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (gany)
  );

  assign o_req_ready = gnt;

  // Pointer moves past the winner, so a lone requester still advances it.
  always_comb begin
    ptr_d = ptr_q;
    if (gany) ptr_d = (int'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  // Idle operands are forced to zero to keep the multiplier quiet.
  always_comb begin
    o_mul_R0 = '0;
    o_mul_I0 = '0;
    o_mul_R1 = '0;
    o_mul_I1 = '0;
    if (gany) begin
      o_mul_R0 = i_req_R0[gidx*W +: W];
      o_mul_I0 = i_req_I0[gidx*W +: W];
      o_mul_R1 = i_req_R1[gidx*W +: W];
      o_mul_I1 = i_req_I1[gidx*W +: W];
    end
  end

  // Tag pipeline: stage k holds the op granted k+1 cycles ago.
  always_comb begin
    tag_d     = '0;
    tag_d.vld = gany;
    tag_d.id  = ID_MAX_W'(gidx);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int k = 1; k < MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign o_res_valid = tag_q[MUL_LAT-1].vld;
  assign o_res_id    = tag_q[MUL_LAT-1].id[ID_W-1:0];
  assign o_res_R     = i_mul_R;
  assign o_res_I     = i_mul_I;

  logic unused_id_hi;
  assign unused_id_hi = ^tag_q[MUL_LAT-1].id;

  always_comb begin
    o_busy = gany;
    for (int k = 0; k < MUL_LAT; k++) o_busy = o_busy | tag_q[k].vld;
  end

`ifdef CMUL_ARB_CONJ_EN
  logic [CONJ_DLY-1:0] conj_q;
  logic                conj_d;

  assign conj_d = gany & i_req_conj[gidx];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      conj_q <= '0;
    end else begin
      conj_q[0] <= conj_d;
      for (int k = 1; k < CONJ_DLY; k++) conj_q[k] <= conj_q[k-1];
    end
  end

  assign o_mul_conj = conj_q[CONJ_DLY-1];
`else
  logic unused_conj;
  assign unused_conj = ^i_req_conj;
  assign o_mul_conj  = 1'b0;
`endif

endmodule
